// File: rtl/start_bit_det_os_pkg.sv
// Shared types and parameter legality checks for the oversampling start-bit detector.
package start_bit_pkg;

  typedef enum logic [1:0] {
    ARM    = 2'd0,
    IDLE   = 2'd1,
    VERIFY = 2'd2,
    BUSY   = 2'd3
  } state_e;

  function automatic bit osr_legal(input int osr);
    return (osr >= 4) && (osr <= 64) && ((osr % 2) == 0);
  endfunction

  function automatic bit vote_legal(input int vote);
    return (vote >= 1) && (vote <= 5) && ((vote % 2) == 1);
  endfunction

  function automatic bit sync_legal(input int stages);
    return stages >= 2;
  endfunction

endpackage

// File: rtl/start_bit_det_os_if.sv
// Serial-pin / RCU side signals of the start-bit detector.
interface start_bit_det_os_if;
  logic sample_en;
  logic serial_in;
  logic frame_done;
  logic filtered_in;
  logic start_bit_detected;
  logic start_confirmed;
  logic false_start;
  logic busy;

  // master: the pin/timer/RCU environment; slave: the detector
  modport master (
    output sample_en, serial_in, frame_done,
    input  filtered_in, start_bit_detected, start_confirmed, false_start, busy
  );

  modport slave (
    input  sample_en, serial_in, frame_done,
    output filtered_in, start_bit_detected, start_confirmed, false_start, busy
  );
endinterface

// File: rtl/start_bit_det_os_sync_vote_filter.sv
// Metastability synchroniser followed by a majority-vote glitch filter clocked by sample_en.
module sync_vote_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   VOTE        = 3,
  parameter logic IDLE_LVL    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic serial_in,
  output logic filtered_out
);

  localparam int CW = $clog2(VOTE + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [VOTE-1:0]        vote_q, vote_d;
  logic [CW-1:0]          ones;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = serial_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_comb begin
    vote_d = vote_q;
    if (sample_en) begin
      vote_d[0] = sync_out;
      for (int unsigned i = 1; i < VOTE; i++) vote_d[i] = vote_q[i-1];
    end
  end

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < VOTE; i++) ones = ones + CW'(vote_q[i]);
  end

  assign filtered_out = (ones > CW'(VOTE / 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IDLE_LVL}};
      vote_q <= {VOTE{IDLE_LVL}};
    end else begin
      sync_q <= sync_d;
      vote_q <= vote_d;
    end
  end

endmodule

// File: rtl/start_bit_det_os.sv
// Oversampling start-bit detector: filtered edge detect, mid-bit verification, RCU rearm handshake.
module start_bit_det_os
  import start_bit_pkg::*;
#(
  parameter int   OSR         = 16,
  parameter int   SYNC_STAGES = 2,
  parameter int   VOTE        = 3,
  parameter logic IDLE_LVL    = 1'b1,
  parameter int   IDLE_QUAL   = 2
) (
  input logic               clk,
  input logic               rst,
  start_bit_det_os_if.slave bus
);

  if (!osr_legal(OSR)) begin : g_osr_chk
    $error("start_bit_det_os: OSR must be even and within 4..64");
  end
  if (!vote_legal(VOTE)) begin : g_vote_chk
    $error("start_bit_det_os: VOTE must be odd and within 1..5");
  end
  if (!sync_legal(SYNC_STAGES)) begin : g_sync_chk
    $error("start_bit_det_os: SYNC_STAGES must be at least 2");
  end
  if (IDLE_QUAL < 1) begin : g_qual_chk
    $error("start_bit_det_os: IDLE_QUAL must be at least 1");
  end

  localparam int CNT_W  = $clog2(OSR);
  localparam int IDLE_W = $clog2(IDLE_QUAL + 1);
  // os_cnt holds the number of ticks already seen since detection, so the
  // (OSR/2)-th tick is the one arriving while the count equals OSR/2-1.
  localparam logic [CNT_W-1:0]  EVAL_AT   = CNT_W'(OSR / 2 - 1);
  localparam logic [IDLE_W-1:0] QUAL_LAST = IDLE_W'(IDLE_QUAL - 1);

  logic filtered;

  sync_vote_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .VOTE        (VOTE),
    .IDLE_LVL    (IDLE_LVL)
  ) u_filter (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (bus.sample_en),
    .serial_in    (bus.serial_in),
    .filtered_out (filtered)
  );

  state_e             state_q, state_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]   os_cnt_q, os_cnt_d;
  logic               filt_prev_q, filt_prev_d;
  logic               det_q, det_d;
  logic               conf_q, conf_d;
  logic               fs_q, fs_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    os_cnt_d    = os_cnt_q;
    filt_prev_d = bus.sample_en ? filtered : filt_prev_q;
    det_d       = 1'b0;
    conf_d      = 1'b0;
    fs_d        = 1'b0;

    unique case (state_q)
      ARM: begin
        if (bus.sample_en) begin
          if (filtered == IDLE_LVL) begin
            if (idle_cnt_q == QUAL_LAST) begin
              idle_cnt_d = '0;
              state_d    = IDLE;
            end else begin
              idle_cnt_d = idle_cnt_q + 1'b1;
            end
          end else begin
            idle_cnt_d = '0;
          end
        end
      end
      IDLE: begin
        if (bus.sample_en && (filt_prev_q == IDLE_LVL) && (filtered != IDLE_LVL)) begin
          det_d    = 1'b1;
          os_cnt_d = '0;
          state_d  = VERIFY;
        end
      end
      VERIFY: begin
        if (bus.sample_en) begin
          if (os_cnt_q == EVAL_AT) begin
            if (filtered != IDLE_LVL) begin
              conf_d  = 1'b1;
              state_d = BUSY;
            end else begin
              fs_d    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      BUSY: begin
        if (bus.frame_done) begin
          idle_cnt_d = '0;
          state_d    = ARM;
        end
      end
      default: state_d = ARM;
    endcase

    busy_d = (state_d == VERIFY) || (state_d == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARM;
      idle_cnt_q  <= '0;
      os_cnt_q    <= '0;
      filt_prev_q <= IDLE_LVL;
      det_q       <= 1'b0;
      conf_q      <= 1'b0;
      fs_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      os_cnt_q    <= os_cnt_d;
      filt_prev_q <= filt_prev_d;
      det_q       <= det_d;
      conf_q      <= conf_d;
      fs_q        <= fs_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.filtered_in        = filtered;
  assign bus.start_bit_detected = det_q;
  assign bus.start_confirmed    = conf_q;
  assign bus.false_start        = fs_q;
  assign bus.busy               = busy_q;

endmodule

// File: tb/tb_start_bit_det_os.sv
// Scenario bench for start_bit_det_os at default parameters; edge k counts from the first low sample.
module tb_start_bit_det_os;
  import start_bit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  start_bit_det_os_if bus();

  start_bit_det_os #(
    .OSR         (16),
    .SYNC_STAGES (2),
    .VOTE        (3),
    .IDLE_LVL    (1'b1),
    .IDLE_QUAL   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // {filtered_in, start_bit_detected, start_confirmed, false_start, busy}
  logic [4:0] exp_q[$];
  logic [4:0] got, exp_v;
  assign got = {bus.filtered_in, bus.start_bit_detected, bus.start_confirmed,
                bus.false_start, bus.busy};

  function automatic logic [4:0] vec(input logic f, input logic d, input logic c,
                                     input logic s, input logic b);
    return {f, d, c, s, b};
  endfunction

  task automatic set_in(input logic se, input logic sin, input logic fd);
    bus.sample_en  = se;
    bus.serial_in  = sin;
    bus.frame_done = fd;
  endtask

  task automatic reset_and_arm();
    rst = 1'b1;
    set_in(1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    set_in(1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL reset k=%0d got %b want %b", k, got, exp_v);
      end
    end
    rst = 1'b0;
    set_in(1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    vectors++;
    if (dut.state_q !== ARM) begin
      miscompares++;
      $display("FAIL reset_arm_tick1 state got %0d want %0d", dut.state_q, ARM);
    end
    @(posedge clk); #1;
    vectors++;
    if (dut.state_q !== IDLE) begin
      miscompares++;
      $display("FAIL reset_arm_tick2 state got %0d want %0d", dut.state_q, IDLE);
    end
  endtask

  task automatic test_clean_start();
    reset_and_arm();
    for (int k = 0; k <= 27; k++) begin
      set_in(1'b1, (k < 16) ? 1'b0 : 1'b1, (k == 25));
      exp_q.push_back(vec(!(k >= 3 && k <= 18), k == 4, k == 12, 1'b0, k >= 4 && k < 25));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL clean_start k=%0d got %b want %b", k, got, exp_v);
      end
    end
    vectors++;
    if (dut.state_q !== IDLE) begin
      miscompares++;
      $display("FAIL clean_start_rearm state got %0d want %0d", dut.state_q, IDLE);
    end
  endtask

  task automatic test_glitch();
    reset_and_arm();
    for (int k = 0; k < 12; k++) begin
      set_in(1'b1, (k == 0) ? 1'b0 : 1'b1, 1'b0);
      exp_q.push_back(vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL glitch k=%0d got %b want %b", k, got, exp_v);
      end
    end
  endtask

  task automatic test_false_start();
    reset_and_arm();
    for (int k = 0; k < 16; k++) begin
      set_in(1'b1, (k < 4) ? 1'b0 : 1'b1, 1'b0);
      exp_q.push_back(vec(!(k >= 3 && k <= 6), k == 4, 1'b0, k == 12, k >= 4 && k <= 11));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL false_start k=%0d got %b want %b", k, got, exp_v);
      end
    end
    vectors++;
    if (dut.state_q !== IDLE) begin
      miscompares++;
      $display("FAIL false_start_state got %0d want %0d", dut.state_q, IDLE);
    end
  endtask

  task automatic test_stuck_line();
    reset_and_arm();
    for (int k = 0; k <= 114; k++) begin
      set_in(1'b1, 1'b0, (k == 14));
      exp_q.push_back(vec(!(k >= 3), k == 4, k == 12, 1'b0, k >= 4 && k < 14));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL stuck_low k=%0d got %b want %b", k, got, exp_v);
      end
    end
    vectors++;
    if (dut.state_q !== ARM) begin
      miscompares++;
      $display("FAIL stuck_low_state got %0d want %0d", dut.state_q, ARM);
    end
    for (int r = 0; r < 10; r++) begin
      set_in(1'b1, 1'b1, 1'b0);
      exp_q.push_back(vec(r >= 3, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL stuck_release r=%0d got %b want %b", r, got, exp_v);
      end
    end
    vectors++;
    if (dut.state_q !== IDLE) begin
      miscompares++;
      $display("FAIL stuck_release_state got %0d want %0d", dut.state_q, IDLE);
    end
  endtask

  task automatic test_sparse_reset();
    reset_and_arm();
    for (int c = 0; c <= 60; c++) begin
      rst = (c == 28 || c == 29);
      set_in((c % 4) == 0, (c < 28) ? 1'b0 : 1'b1, 1'b0);
      if (c < 28) exp_q.push_back(vec(!(c >= 8), c == 12, 1'b0, 1'b0, c >= 12));
      else        exp_q.push_back(vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL sparse_reset c=%0d got %b want %b", c, got, exp_v);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    set_in(1'b0, 1'b1, 1'b0);
    test_reset();
    test_clean_start();
    test_glitch();
    test_false_start();
    test_stuck_line();
    test_sparse_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1, "watchdog");
  end

endmodule
